// File: rtl/inv_mix_columns_iter_if.sv
// Handshake bundle for the iterative InvMixColumns engine: state in, result out, status.
interface inv_mix_columns_iter_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] state_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] state_out;
    logic         busy;

    modport master (
        output in_valid, state_in, out_ready,
        input  in_ready, out_valid, state_out, busy
    );

    modport slave (
        input  in_valid, state_in, out_ready,
        output in_ready, out_valid, state_out, busy
    );
endinterface

// File: rtl/inv_mix_columns_iter.sv
// Iterative AES InvMixColumns: loads a 128-bit state, rewrites COLS_PER_CYCLE columns per
// clock in place, then holds the result until the consumer takes it.

// Single-column InvMixColumns, purely combinational; row 0 is the MSB byte.
module inv_mix_column (
    input  logic [31:0] col,
    output logic [31:0] mixed
);
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    logic [7:0] a  [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];

    always_comb begin
        logic [7:0] x2, x4, x8;
        mixed = '0;
        for (int r = 0; r < 4; r++) begin
            a[r]  = col[31-8*r -: 8];
            x2    = xtime(a[r]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[r] = x8 ^ a[r];
            mb[r] = x8 ^ x2 ^ a[r];
            md[r] = x8 ^ x4 ^ a[r];
            me[r] = x8 ^ x4 ^ x2;
        end
        for (int r = 0; r < 4; r++) begin
            mixed[31-8*r -: 8] = me[r] ^ mb[(r+1)%4] ^ md[(r+2)%4] ^ m9[(r+3)%4];
        end
    end
endmodule

module inv_mix_columns_iter #(
    parameter int unsigned COLS_PER_CYCLE = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    inv_mix_columns_iter_if.slave        bus
);
    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
        $error("inv_mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    localparam logic [1:0] ColStep = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LastCol = 2'(4 - COLS_PER_CYCLE);

    state_e         state_q, state_d;
    logic [127:0]   work_q, work_d;
    logic [1:0]     col_idx_q, col_idx_d;
    logic [127:0]   work_step;
    logic [31:0]    cols     [4];
    logic [31:0]    lane_in  [COLS_PER_CYCLE];
    logic [31:0]    lane_out [COLS_PER_CYCLE];

    logic           in_ready, out_valid, busy;
    logic [127:0]   state_out;

    always_comb begin
        for (int c = 0; c < 4; c++) begin
            cols[c] = work_q[127-32*c -: 32];
        end
    end

    for (genvar j = 0; j < COLS_PER_CYCLE; j++) begin : g_lane
        assign lane_in[j] = cols[col_idx_q + 2'(j)];
        inv_mix_column u_col (
            .col   (lane_in[j]),
            .mixed (lane_out[j])
        );
    end

    // col_idx is always a multiple of COLS_PER_CYCLE, so column c belongs to lane c % N.
    always_comb begin
        work_step = work_q;
        for (int c = 0; c < 4; c++) begin
            if (col_idx_q == 2'(c - (c % COLS_PER_CYCLE))) begin
                work_step[127-32*c -: 32] = lane_out[c % COLS_PER_CYCLE];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            work_q    <= '0;
            col_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            work_q    <= work_d;
            col_idx_q <= col_idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        work_d    = work_q;
        col_idx_d = col_idx_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        state_out = '0;
        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    work_d    = bus.state_in;
                    col_idx_d = '0;
                    state_d   = StBusy;
                end
            end
            StBusy: begin
                busy      = 1'b1;
                work_d    = work_step;
                col_idx_d = col_idx_q + ColStep;
                if (col_idx_q == LastCol) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                out_valid = 1'b1;
                state_out = work_q;
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.busy      = busy;
    assign bus.state_out = state_out;
endmodule

// File: tb/tb_inv_mix_columns_iter.sv
// Directed and round-trip bench for inv_mix_columns_iter at COLS_PER_CYCLE = 1, 2 and 4.
module tb_inv_mix_columns_iter;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [127:0] state_in;
    logic         out_ready;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    inv_mix_columns_iter_if b1 ();
    inv_mix_columns_iter_if b2 ();
    inv_mix_columns_iter_if b4 ();

    assign b1.in_valid  = in_valid;
    assign b2.in_valid  = in_valid;
    assign b4.in_valid  = in_valid;
    assign b1.state_in  = state_in;
    assign b2.state_in  = state_in;
    assign b4.state_in  = state_in;
    assign b1.out_ready = out_ready;
    assign b2.out_ready = out_ready;
    assign b4.out_ready = out_ready;

    inv_mix_columns_iter #(.COLS_PER_CYCLE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    inv_mix_columns_iter #(.COLS_PER_CYCLE(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));
    inv_mix_columns_iter #(.COLS_PER_CYCLE(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));

    logic         ov [3];
    logic         ir [3];
    logic         bz [3];
    logic [127:0] so [3];
    int           cpc [3] = '{1, 2, 4};

    assign ov[0] = b1.out_valid;  assign ov[1] = b2.out_valid;  assign ov[2] = b4.out_valid;
    assign ir[0] = b1.in_ready;   assign ir[1] = b2.in_ready;   assign ir[2] = b4.in_ready;
    assign bz[0] = b1.busy;       assign bz[1] = b2.busy;       assign bz[2] = b4.busy;
    assign so[0] = b1.state_out;  assign so[1] = b2.state_out;  assign so[2] = b4.state_out;

    task automatic chk(input string name, input int d, input logic [127:0] got,
                       input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s[cpc=%0d] got=%0h want=%0h", name, cpc[d], got, exp);
        end
    endtask

    // Forward MixColumns reference, independent of the engine under test.
    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] fwd_mix(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0] a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            {a0, a1, a2, a3} = s[127-32*c -: 32];
            r[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                                 a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                                 a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                                 xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
        end
        return r;
    endfunction

    // One accept at edge k with out_ready high; checks result and the cycle out_valid rises.
    task automatic transact(input string name, input logic [127:0] din, input logic [127:0] exp);
        int lat [3];
        logic [127:0] got [3];
        for (int d = 0; d < 3; d++) begin
            lat[d] = 0;
            got[d] = '0;
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        state_in  = din;
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (n == 1) begin
                chk({name, "_busy"}, 0, {127'b0, bz[0]}, 128'd1);
                chk({name, "_noready"}, 0, {127'b0, ir[0]}, 128'd0);
            end
            for (int d = 0; d < 3; d++) begin
                if (lat[d] == 0 && ov[d]) begin
                    lat[d] = n;
                    got[d] = so[d];
                end
            end
        end
        for (int d = 0; d < 3; d++) begin
            chk({name, "_latency"}, d, 128'(lat[d]), 128'(4 / cpc[d]));
            chk({name, "_data"}, d, got[d], exp);
        end
    endtask

    typedef struct {
        string        name;
        logic [127:0] din;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs [4];

    initial begin
        logic [127:0] held;
        logic [127:0] orig;

        vecs[0] = '{"known", 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6,
                             128'hdb135345_f20a225c_01010101_c6c6c6c6};
        vecs[1] = '{"second", 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff,
                              128'hd4d4d4d5_2d26314c_00000000_ffffffff};
        vecs[2] = '{"unit", 128'h01000000_00010000_00000100_00000001,
                            128'h0e090d0b_0b0e090d_0d0b0e09_090d0b0e};
        vecs[3] = '{"msb", 128'h80000000_00000000_00000000_00000000,
                           128'h41ecdaf7_00000000_00000000_00000000};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        state_in  = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("rst_in_ready", d, {127'b0, ir[d]}, 128'd1);
            chk("rst_out_valid", d, {127'b0, ov[d]}, 128'd0);
            chk("rst_busy", d, {127'b0, bz[d]}, 128'd0);
            chk("rst_state_out", d, so[d], 128'd0);
        end

        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            transact(vecs[i].name, vecs[i].din, vecs[i].exp);
            #1;
        end

        // Backpressure: all three reach DONE and must hold while in_valid toggles.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        state_in  = vecs[0].din;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        for (int cyc = 0; cyc < 7; cyc++) begin
            in_valid = (cyc % 2 == 0) && (cyc != 6);
            state_in = vecs[1].din;
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                chk("bp_out_valid", d, {127'b0, ov[d]}, 128'd1);
                chk("bp_in_ready", d, {127'b0, ir[d]}, 128'd0);
                chk("bp_stable", d, so[d], vecs[0].exp);
            end
            @(posedge clk);
            #1;
        end
        // Release with in_valid also high: only the output handshake may complete.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("release_out_valid", d, {127'b0, ov[d]}, 128'd0);
            chk("release_idle", d, {127'b0, ir[d]}, 128'd1);
            chk("release_no_accept", d, {127'b0, bz[d]}, 128'd0);
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;

        // Abort mid-operation: reset one edge after accept.
        in_valid = 1'b1;
        state_in = vecs[0].din;
        @(posedge clk);
        #1 in_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                chk("abort_no_valid", d, {127'b0, ov[d]}, 128'd0);
            end
        end
        @(posedge clk);
        #1;
        transact("post_abort", vecs[1].din, vecs[1].exp);
        #1;

        for (int i = 0; i < 1000; i++) begin
            orig = {$urandom(), $urandom(), $urandom(), $urandom()};
            held = fwd_mix(orig);
            transact("roundtrip", held, orig);
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
